// File: rtl/sc_lane_shifter.sv
// sc_lane_shifter
// Holds one lane's obstacle pattern and rotates it by one cell every
// Period+3 clocks while enabled. Each rotate or load is followed by a
// single SEND cycle that raises the send strobe for the downstream delay stage.
// Optional build macro: LANESHIFTER_POSITION_EN adds a rotation position
// output (SC_LANESHIFTER_Position_outBus).
module sc_lane_shifter #(
    parameter int                       DATAWIDTH_BUS   = 8,
    parameter int                       PRESCALER_WIDTH = 24,
    parameter logic [DATAWIDTH_BUS-1:0] INIT_PATTERN    = DATAWIDTH_BUS'(3)
) (
    input  logic                       SC_LANESHIFTER_CLOCK_50,
    input  logic                       SC_LANESHIFTER_RESET_InHigh,
    input  logic                       SC_LANESHIFTER_Load_In,
    input  logic [DATAWIDTH_BUS-1:0]   SC_LANESHIFTER_Pattern_inBus,
    input  logic                       SC_LANESHIFTER_Enable_In,
    input  logic                       SC_LANESHIFTER_Direction_In,
    input  logic [PRESCALER_WIDTH-1:0] SC_LANESHIFTER_Period_inBus,
    output logic [DATAWIDTH_BUS-1:0]   SC_LANESHIFTER_Data_outBus,
    output logic                       SC_LANESHIFTER_SendDataSignal_Out,
    output logic [1:0]                 SC_LANESHIFTER_State_outBus
`ifdef LANESHIFTER_POSITION_EN
    ,
    output logic [$clog2(DATAWIDTH_BUS)-1:0] SC_LANESHIFTER_Position_outBus
);
`else
);
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        SHIFT = 2'd2,
        SEND  = 2'd3
    } state_t;

    state_t                     state_reg;
    state_t                     state_next;
    logic [PRESCALER_WIDTH-1:0] counter_reg;
    logic [DATAWIDTH_BUS-1:0]   data_reg;
    logic [DATAWIDTH_BUS-1:0]   rot_left;
    logic [DATAWIDTH_BUS-1:0]   rot_right;
    logic                       count_done;

    // Period is compared live, so lowering it below the running count
    // ends the COUNT phase on the very next edge.
    assign count_done = (counter_reg >= SC_LANESHIFTER_Period_inBus);

    // One-cell rotations of the lane: left moves cells toward the MSB with the
    // MSB wrapping into bit 0; right moves toward the LSB with bit 0 wrapping
    // into the MSB.
    generate
        for (genvar gi = 0; gi < DATAWIDTH_BUS; gi++) begin : g_rot
            assign rot_left[gi]  = data_reg[(gi + DATAWIDTH_BUS - 1) % DATAWIDTH_BUS];
            assign rot_right[gi] = data_reg[(gi + 1) % DATAWIDTH_BUS];
        end
    endgenerate

    // State register.
    always_ff @(posedge SC_LANESHIFTER_CLOCK_50 or posedge SC_LANESHIFTER_RESET_InHigh) begin
        if (SC_LANESHIFTER_RESET_InHigh) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; a load overrides whatever the FSM was about to do.
    always_comb begin
        state_next = state_reg;
        if (SC_LANESHIFTER_Load_In) begin
            state_next = SEND;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (SC_LANESHIFTER_Enable_In) begin
                        state_next = COUNT;
                    end
                end
                COUNT: begin
                    if (!SC_LANESHIFTER_Enable_In) begin
                        state_next = IDLE;
                    end else if (count_done) begin
                        state_next = SHIFT;
                    end
                end
                SHIFT: begin
                    state_next = SEND;
                end
                SEND: begin
                    state_next = SC_LANESHIFTER_Enable_In ? COUNT : IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Moore outputs: the strobe is high exactly while presenting new data.
    always_comb begin
        SC_LANESHIFTER_SendDataSignal_Out = (state_reg == SEND);
        SC_LANESHIFTER_State_outBus       = state_reg;
    end

    // Prescaler counter: only advances while counting and below the limit, so
    // it can never wrap; every other path leaves it cleared.
    always_ff @(posedge SC_LANESHIFTER_CLOCK_50 or posedge SC_LANESHIFTER_RESET_InHigh) begin
        if (SC_LANESHIFTER_RESET_InHigh) begin
            counter_reg <= '0;
        end else if (SC_LANESHIFTER_Load_In) begin
            counter_reg <= '0;
        end else if ((state_reg == COUNT) && SC_LANESHIFTER_Enable_In && !count_done) begin
            counter_reg <= counter_reg + PRESCALER_WIDTH'(1);
        end else begin
            counter_reg <= '0;
        end
    end

    // Lane pattern register: load wins over a rotate scheduled on the same edge.
    always_ff @(posedge SC_LANESHIFTER_CLOCK_50 or posedge SC_LANESHIFTER_RESET_InHigh) begin
        if (SC_LANESHIFTER_RESET_InHigh) begin
            data_reg <= INIT_PATTERN;
        end else if (SC_LANESHIFTER_Load_In) begin
            data_reg <= SC_LANESHIFTER_Pattern_inBus;
        end else if (state_reg == SHIFT) begin
            data_reg <= SC_LANESHIFTER_Direction_In ? rot_right : rot_left;
        end
    end

    assign SC_LANESHIFTER_Data_outBus = data_reg;

`ifdef LANESHIFTER_POSITION_EN
    localparam int POS_W = $clog2(DATAWIDTH_BUS);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(DATAWIDTH_BUS - 1);

    logic [POS_W-1:0] position_reg;

    // Rotation position modulo lane width, moving in step with the data.
    always_ff @(posedge SC_LANESHIFTER_CLOCK_50 or posedge SC_LANESHIFTER_RESET_InHigh) begin
        if (SC_LANESHIFTER_RESET_InHigh) begin
            position_reg <= '0;
        end else if (SC_LANESHIFTER_Load_In) begin
            position_reg <= '0;
        end else if (state_reg == SHIFT) begin
            if (SC_LANESHIFTER_Direction_In) begin
                position_reg <= (position_reg == '0) ? POS_LAST : position_reg - POS_W'(1);
            end else begin
                position_reg <= (position_reg == POS_LAST) ? '0 : position_reg + POS_W'(1);
            end
        end
    end

    assign SC_LANESHIFTER_Position_outBus = position_reg;
`endif

endmodule

// File: doc/sc_lane_shifter.md
Name: sc_lane_shifter

Overview:
Upstream stage of the lane data-delay block in the Frogger datapath. Holds one lane's obstacle pattern (cars/logs) and rotates it by one bit every programmable number of clocks. After each rotate or load, emits the updated pattern on a data bus together with a one-cycle send strobe, which the downstream delay stage consumes directly.

Parameters:
DATAWIDTH_BUS, 8, lane pattern width in bits (one bit per lane cell); minimum 2
PRESCALER_WIDTH, 24, width of the period input and the internal clock counter
INIT_PATTERN, 8'h03, pattern value loaded on reset (width DATAWIDTH_BUS)

Ports:
SC_LANESHIFTER_CLOCK_50  in  1  system clock; all state changes on its rising edge
SC_LANESHIFTER_RESET_InHigh  in  1  asynchronous, active-high reset
SC_LANESHIFTER_Load_In  in  1  load Pattern_inBus into the lane register (level, sampled each clock)
SC_LANESHIFTER_Pattern_inBus  in  DATAWIDTH_BUS  pattern to load
SC_LANESHIFTER_Enable_In  in  1  1 = lane moving; 0 = lane frozen
SC_LANESHIFTER_Direction_In  in  1  0 = rotate left (toward MSB), 1 = rotate right
SC_LANESHIFTER_Period_inBus  in  PRESCALER_WIDTH  count limit P; shift interval is P+3 clocks
SC_LANESHIFTER_Data_outBus  out  DATAWIDTH_BUS  current lane pattern (registered)
SC_LANESHIFTER_SendDataSignal_Out  out  1  one-cycle strobe; Data_outBus is valid and new while high
SC_LANESHIFTER_State_outBus  out  2  FSM state: IDLE=0, COUNT=1, SHIFT=2, SEND=3

Behaviour:
- Clock and reset: one clock, SC_LANESHIFTER_CLOCK_50. SC_LANESHIFTER_RESET_InHigh is asynchronous and active-high.
- Reset, effective immediately, no clock required:
  - Data_outBus = INIT_PATTERN, SendDataSignal_Out = 0, state = IDLE, counter = 0.
  - Reset asserted mid-operation aborts any pending shift or strobe.
- FSM, evaluated on each rising clock edge. Load has top priority:
  - IDLE: counter held at 0. Enable=1 -> COUNT.
  - COUNT: counter increments by 1. When counter >= Period_inBus -> SHIFT and counter cleared. Enable=0 -> IDLE, counter cleared, data held, no strobe.
  - SHIFT: one cycle. Register rotates one position; Direction_In is sampled in this cycle. Left: {d[W-2:0], d[W-1]}. Right: {d[0], d[W-1:1]}. -> SEND.
  - SEND: one cycle, SendDataSignal_Out = 1. Then -> COUNT if Enable=1, else IDLE.
- Load_In=1 in any state:
  - Register <= Pattern_inBus, counter cleared, next state = SEND.
  - A shift scheduled in the same edge is dropped.
  - Load with Enable=0 gives SEND, then IDLE.
  - Load held high keeps reloading, with SEND repeated every cycle.
- Strobe timing: Moore output, high exactly while state==SEND. Data_outBus is already updated in that cycle and stays stable until the next SHIFT or load.
- Period rules:
  - P=0: COUNT lasts 1 cycle, interval 3.
  - Period_inBus is compared live with >=, so lowering it below the current count causes a shift on the next edge.
  - Counter never wraps.
- Enable toggled during SHIFT or SEND has no effect until SEND exits.

Optional Feature:
Macro LANESHIFTER_POSITION_EN.
- Defined:
  - Adds output port SC_LANESHIFTER_Position_outBus, width $clog2(DATAWIDTH_BUS).
  - Value is +1 per left rotate and -1 per right rotate, modulo DATAWIDTH_BUS.
  - Cleared to 0 on reset and on load.
  - Updates on the same edge as the data.
- Not defined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Reset pulse mid-COUNT, asynchronous between edges -> Data_outBus=0x03, strobe=0, State_outBus=0 before the next edge.
- Enable=1, P=4, Dir=0 from 0x03 -> strobe every 7 clocks. Data sequence 0x06, 0x0C, 0x18, 0x30, 0x60, 0xC0, 0x81 (wrap).
- Enable=1, P=0, Dir=1 from 0x03 -> strobe every 3 clocks. Data sequence 0x81, 0xC0, 0x60.
- Load=1 for one cycle with 0xA5 while in COUNT (counter=2, P=4) -> next cycle state=SEND, data=0xA5, strobe=1. Next shift strobe 7 clocks later with data 0x4B.
- Enable dropped at counter=3 (P=10) -> state IDLE, no strobe, data held. Enable restored -> first strobe 13 clocks after re-entering COUNT.
- P=100, counter=50, Period changed to 2 -> SHIFT on the next edge, strobe one clock later. With LANESHIFTER_POSITION_EN, position increments 0->1.
